mines_game_ctrl: RTL
====================

# mines_game_ctrl

Game sequencer for the 4x4 mines game. Drives the bomb-placement block through reset and settle, then latches its 16-bit bomb grid. Accepts one cell pick per cycle from the player interface and tracks revealed cells. Declares loss on a bomb hit, win when every safe cell is revealed, or cash-out on request. Sits between the player/UI logic and `multi_bomb_placement`.

## Interface
Parameters:
- `PLACE_WAIT`, 2: cycles the placement block runs after its reset is released before `bomb_grid` is sampled (1..15).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a round; sampled in IDLE, WON, LOST, CASHED.
- `bomb_count`  in  4  requested bombs; sampled on accepted `start`.
- `place_reset`  out  1  drives the placement block's `reset`.
- `place_bomb_count`  out  4  drives the placement block's `bomb_count`.
- `bomb_grid`  in  16  from the placement block; bit i = row i/4, col i%4.
- `pick_valid`  in  1  a pick is offered this cycle.
- `pick_idx`  in  4  cell index 0..15.
- `cashout`  in  1  end the round keeping the current score.
- `pick_ready`  out  1  high only in PLAY.
- `revealed`  out  16  cells revealed this round.
- `score`  out  4  safe cells revealed (0..15).
- `pick_dup`  out  1  1-cycle pulse: the accepted pick targeted an already-revealed cell.
- `hit_idx`  out  4  cell that caused the loss; valid in LOST.
- `playing`, `won`, `lost`, `cashed`  out  1 each  state flags, mutually exclusive.

## Operation
- States: IDLE, PLACE, PLAY, WON, LOST, CASHED.
- IDLE: `place_reset`=1. On `start`:
  - Latch `req_cnt` = (`bomb_count`==0) ? 1 : `bomb_count`.
  - Clear `revealed`, `score`, `hit_idx`, and the wait counter.
  - Go to PLACE.
- PLACE: `place_reset`=0. Count up each cycle. When the count reaches `PLACE_WAIT`-1:
  - Latch `grid_q` = `bomb_grid`.
  - Latch `bombs_q` = popcount(`bomb_grid`), 5 bits.
  - Go to PLAY.
  - If popcount is 0, `bombs_q` is forced to `req_cnt` and `grid_q` is used as is. The game stays playable and a win is reached at 16-`req_cnt` reveals.
- PLAY: `place_reset`=0, `pick_ready`=1. A pick is accepted when `pick_valid` is high in PLAY. Priority: `cashout`, then pick.
  - `cashout`: go to CASHED. A pick in the same cycle is discarded.
  - Pick on an already-revealed cell: no state change; pulse `pick_dup` next cycle.
  - Pick on a bomb (`grid_q[pick_idx]`=1): set `revealed[pick_idx]`, `hit_idx`=`pick_idx`, go to LOST. `score` is unchanged.
  - Pick on a safe cell: set `revealed[pick_idx]` and increment `score`. If the new `score` == 16-`bombs_q`, go to WON, else stay in PLAY.
- WON, LOST, CASHED: hold `revealed`, `score`, and `hit_idx`; `place_reset`=1. On `start`, behave exactly as `start` in IDLE.
- `start` in PLACE or PLAY is ignored.
- `place_bomb_count` = `req_cnt` at all times.
- `reset` at any cycle, including mid-PLACE or mid-PLAY, forces IDLE next edge. Reset values:
  - `place_reset`=1.
  - `req_cnt`=1, so `place_bomb_count`=1.
  - `pick_ready`=0.
  - `revealed`, `score`, `hit_idx`, `pick_dup`, `playing`, `won`, `lost`, `cashed` all 0.
  - `grid_q`, `bombs_q`, and the wait counter cleared.

## Timing
- All outputs are registered or decoded from the state register; there is no combinational path from input to output.
- Accepted `start` at edge t: PLACE from t+1, and `place_reset` falls at t+1.
- `bomb_grid` is sampled at edge t+`PLACE_WAIT`. PLAY is entered at t+`PLACE_WAIT`+1.
- Pick accepted at edge p: `revealed`, `score`, and state updated at p+1. `pick_dup` is high only during cycle p+1.
- Throughput is one pick per cycle in PLAY, with no bubbles.
- In the cycle a pick causes WON or LOST, `pick_ready` drops at the next edge. Picks offered in the terminal state are ignored.

## Structure
- Shared package `mines_pkg`:
  - `GRID_CELLS`=16, `CELL_IDX_W`=4.
  - The state enum `mines_state_t`.
  - Function `popcount16`.
- One sub-module, `mines_reveal_tracker`. It holds `revealed`, `score`, and `hit_idx`, and evaluates hit/dup/safe for a pick against `grid_q`. The FSM stays in the top module.

## Test plan
- Reset held 3 cycles mid-PLAY → all outputs at reset values next cycle. `place_reset`=1, state IDLE.
- `start` with `bomb_count`=0 → `place_bomb_count`=1. `place_reset` is low for exactly `PLACE_WAIT` cycles before PLAY.
- Forced `bomb_grid`=16'h0001, 15 distinct safe picks 1..15 on consecutive cycles → `score` climbs to 15. `won`=1 the cycle after the 15th pick, `revealed`=16'hFFFE.
- `bomb_grid`=16'h8421, picks 1 then 5 → after pick 1, `score`=1. After pick 5: `lost`=1, `hit_idx`=5, `revealed`=16'h0022, `score` stays 1.
- Pick 2 twice, then a same-cycle `cashout` and pick 3 → second pick 2 gives a `pick_dup` pulse with `score`=1. Then `cashed`=1, `score`=1, `revealed[3]`=0.
- `start` asserted in PLAY → ignored. `start` in LOST → `revealed`=0, `score`=0, state PLACE next cycle.

Source files
------------

// File: rtl/mines_pkg.sv
// Shared types, sizes and helpers for the mines game sequencer.
package mines_pkg;

  localparam int unsigned GRID_CELLS = 16;
  localparam int unsigned CELL_IDX_W = 4;
  localparam int unsigned SCORE_W    = 4;
  localparam int unsigned BOMBS_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLACE,
    ST_PLAY,
    ST_WON,
    ST_LOST,
    ST_CASHED
  } mines_state_t;

  // Number of set bits in a 16-cell grid; 5 bits so a full grid reads as 16.
  function automatic logic [BOMBS_W-1:0] popcount16(input logic [GRID_CELLS-1:0] v);
    logic [BOMBS_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(GRID_CELLS); i++) begin
      n = n + BOMBS_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/mines_game_ctrl_if.sv
// Player-side and placement-side signals of the mines game sequencer.
interface mines_game_ctrl_if;
  import mines_pkg::*;

  logic                  start;
  logic [3:0]            bomb_count;
  logic                  place_reset;
  logic [3:0]            place_bomb_count;
  logic [GRID_CELLS-1:0] bomb_grid;
  logic                  pick_valid;
  logic [CELL_IDX_W-1:0] pick_idx;
  logic                  cashout;
  logic                  pick_ready;
  logic [GRID_CELLS-1:0] revealed;
  logic [SCORE_W-1:0]    score;
  logic                  pick_dup;
  logic [CELL_IDX_W-1:0] hit_idx;
  logic                  playing;
  logic                  won;
  logic                  lost;
  logic                  cashed;

  // Player / placement-block side
  modport master (
    output start, bomb_count, bomb_grid, pick_valid, pick_idx, cashout,
    input  place_reset, place_bomb_count, pick_ready, revealed, score,
           pick_dup, hit_idx, playing, won, lost, cashed
  );

  // Sequencer side
  modport slave (
    input  start, bomb_count, bomb_grid, pick_valid, pick_idx, cashout,
    output place_reset, place_bomb_count, pick_ready, revealed, score,
           pick_dup, hit_idx, playing, won, lost, cashed
  );

endinterface

// File: rtl/mines_reveal_tracker.sv
// Holds the revealed mask, score and hit cell; classifies each pick against the grid.
module mines_reveal_tracker
  import mines_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  pick_en,
  input  logic [CELL_IDX_W-1:0] pick_idx,
  input  logic [GRID_CELLS-1:0] grid,
  output logic [GRID_CELLS-1:0] revealed,
  output logic [SCORE_W-1:0]    score,
  output logic [CELL_IDX_W-1:0] hit_idx,
  output logic                  pick_dup,
  output logic                  dup_c,
  output logic                  hit_c,
  output logic                  safe_c
);

  // A revealed cell is never re-scored, so dup masks both hit and safe.
  always_comb begin
    dup_c  = revealed[pick_idx];
    hit_c  = !dup_c && grid[pick_idx];
    safe_c = !dup_c && !grid[pick_idx];
  end

  // Reveal/score update on an accepted pick; dup flag is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      revealed <= '0;
      score    <= '0;
      hit_idx  <= '0;
      pick_dup <= 1'b0;
    end else begin
      pick_dup <= 1'b0;
      if (pick_en) begin
        if (dup_c) begin
          pick_dup <= 1'b1;
        end else begin
          revealed[pick_idx] <= 1'b1;
          if (hit_c) begin
            hit_idx <= pick_idx;
          end else begin
            score <= score + SCORE_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/mines_game_ctrl.sv
// Round sequencer: runs bomb placement, takes picks, decides win/loss/cash-out.
module mines_game_ctrl
  import mines_pkg::*;
#(
  parameter int unsigned PLACE_WAIT = 2
) (
  input logic               clk,
  input logic               reset,
  mines_game_ctrl_if.slave  bus
);

  mines_state_t          state, state_next;
  logic [3:0]            req_cnt;
  logic [3:0]            wait_cnt;
  logic [GRID_CELLS-1:0] grid_q;
  logic [BOMBS_W-1:0]    bombs_q;
  logic [BOMBS_W-1:0]    grid_pop;
  logic [BOMBS_W-1:0]    win_target;
  logic [BOMBS_W-1:0]    score_inc;
  logic                  start_ok;
  logic                  place_done;
  logic                  pick_en;
  logic                  dup_c;
  logic                  hit_c;
  logic                  safe_c;
  logic [GRID_CELLS-1:0] revealed;
  logic [SCORE_W-1:0]    score;
  logic [CELL_IDX_W-1:0] hit_idx;
  logic                  pick_dup;

  // Acceptance conditions and the win threshold for the current round.
  always_comb begin
    start_ok   = bus.start && (state inside {ST_IDLE, ST_WON, ST_LOST, ST_CASHED});
    place_done = (state == ST_PLACE) && (wait_cnt == 4'(PLACE_WAIT - 1));
    pick_en    = (state == ST_PLAY) && bus.pick_valid && !bus.cashout;
    grid_pop   = popcount16(bus.bomb_grid);
    win_target = BOMBS_W'(GRID_CELLS) - bombs_q;
    score_inc  = {1'b0, score} + BOMBS_W'(1);
  end

  // Next-state logic; cash-out outranks a same-cycle pick.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_WON, ST_LOST, ST_CASHED: begin
        if (bus.start) state_next = ST_PLACE;
      end
      ST_PLACE: begin
        if (place_done) state_next = ST_PLAY;
      end
      ST_PLAY: begin
        if (bus.cashout) begin
          state_next = ST_CASHED;
        end else if (bus.pick_valid) begin
          if (hit_c) begin
            state_next = ST_LOST;
          end else if (safe_c && (score_inc == win_target)) begin
            state_next = ST_WON;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register plus state flags registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      bus.place_reset <= 1'b1;
      bus.pick_ready  <= 1'b0;
      bus.playing     <= 1'b0;
      bus.won         <= 1'b0;
      bus.lost        <= 1'b0;
      bus.cashed      <= 1'b0;
    end else begin
      state           <= state_next;
      bus.place_reset <= !(state_next inside {ST_PLACE, ST_PLAY});
      bus.pick_ready  <= (state_next == ST_PLAY);
      bus.playing     <= (state_next == ST_PLAY);
      bus.won         <= (state_next == ST_WON);
      bus.lost        <= (state_next == ST_LOST);
      bus.cashed      <= (state_next == ST_CASHED);
    end
  end

  // Round setup and grid capture; an empty grid falls back to the requested count.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_cnt  <= 4'd1;
      wait_cnt <= '0;
      grid_q   <= '0;
      bombs_q  <= '0;
    end else if (start_ok) begin
      req_cnt  <= (bus.bomb_count == 4'd0) ? 4'd1 : bus.bomb_count;
      wait_cnt <= '0;
    end else if (state == ST_PLACE) begin
      if (place_done) begin
        grid_q  <= bus.bomb_grid;
        bombs_q <= (grid_pop == '0) ? BOMBS_W'(req_cnt) : grid_pop;
      end else begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

  mines_reveal_tracker u_tracker (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_ok),
    .pick_en  (pick_en),
    .pick_idx (bus.pick_idx),
    .grid     (grid_q),
    .revealed (revealed),
    .score    (score),
    .hit_idx  (hit_idx),
    .pick_dup (pick_dup),
    .dup_c    (dup_c),
    .hit_c    (hit_c),
    .safe_c   (safe_c)
  );

  assign bus.place_bomb_count = req_cnt;
  assign bus.revealed         = revealed;
  assign bus.score            = score;
  assign bus.hit_idx          = hit_idx;
  assign bus.pick_dup         = pick_dup;

endmodule
